// File: rtl/jtag_mem_loader_if.sv
// Load-stream and memory-write-port bundle between the loader and its neighbours.
// master: loader side (consumes Jen/Jin, drives echo, write port and status).
// slave : stream source / memory / core side (drives Jen/Jin, observes the rest).
interface jtag_mem_loader_if #(
   parameter int WIDTH = 32,
   parameter int AW    = 9
);
   logic             Jen;        // load enable, one word per cycle while high
   logic [WIDTH-1:0] Jin;        // load word
   logic [WIDTH-1:0] Jout;       // registered echo of the last accepted word
   logic             dmem_we;    // data-memory write strobe
   logic             imem_we;    // instruction-memory write strobe
   logic [AW-1:0]    mem_addr;   // shared write address
   logic [WIDTH-1:0] mem_wdata;  // shared write data
   logic             cpu_hold;   // core idle while high
   logic             load_done;  // all words written
   logic             load_ovf;   // sticky: word offered after completion

   modport master (
      input  Jen, Jin,
      output Jout, dmem_we, imem_we, mem_addr, mem_wdata,
             cpu_hold, load_done, load_ovf
   );

   modport slave (
      output Jen, Jin,
      input  Jout, dmem_we, imem_we, mem_addr, mem_wdata,
             cpu_hold, load_done, load_ovf
   );
endinterface

// File: rtl/jtag_mem_loader.sv
// Purpose : fills data memory then instruction memory (2*DEPTH words, highest
//           address first in each region) from the Jen/Jin stream, holding the core meanwhile.
// Latency : write port registered, strobe/addr/data appear 1 cycle after the accepting edge.
// Backpressure: none; Jen=0 simply pauses the load, words offered after completion set load_ovf.
// Ports   : clk, rst (sync, active-high); bus (jtag_mem_loader_if.master) carries
//           Jen/Jin in, Jout echo, dmem_we/imem_we/mem_addr/mem_wdata, cpu_hold/load_done/load_ovf.
module jtag_mem_loader #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 512,
   parameter int AW    = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   jtag_mem_loader_if.master     bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   // One bit wider than the word index so the terminal count 2*DEPTH is
   // representable and the counter can rest there instead of wrapping.
   localparam int CW = AW + 2;
   localparam logic [CW-1:0] LAST_IDX = CW'(2 * DEPTH - 1);
   localparam logic [CW-1:0] ONE      = CW'(1);

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          accept;

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      accept   = bus.Jen && (state != DONE);
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nx = LOAD;
               cnt_nx   = cnt + ONE;
            end
         end
         LOAD: begin
            if (accept) begin
               cnt_nx = cnt + ONE;
               if (cnt == LAST_IDX) begin
                  state_nx = DONE;
               end
            end
         end
         DONE: begin
            state_nx = DONE;
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   // ---------------- status outputs (decoded from registered state) ----------------
   always_comb begin
      bus.cpu_hold  = (state == LOAD);
      bus.load_done = (state == DONE);
   end

   // ---------------- registered write port and echo ----------------
   // Region comes from bit AW of the index; the address is the inverted low
   // bits so index 0 lands at DEPTH-1 and index DEPTH-1 at 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.Jout      <= '0;
         bus.dmem_we   <= 1'b0;
         bus.imem_we   <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.load_ovf  <= 1'b0;
      end else begin
         bus.dmem_we <= 1'b0;
         bus.imem_we <= 1'b0;
         if (accept) begin
            bus.Jout      <= bus.Jin;
            bus.mem_wdata <= bus.Jin;
            bus.mem_addr  <= ~cnt[AW-1:0];
            bus.dmem_we   <= ~cnt[AW];
            bus.imem_we   <= cnt[AW];
         end
         if ((state == DONE) && bus.Jen) begin
            bus.load_ovf <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_jtag_mem_loader.sv
// Directed bench for jtag_mem_loader: full load with pause, overflow, post-load
// reset, mid-load reset and reset/enable collision; a small memory model
// commits strobed writes so placement can be checked against hand-computed addresses.
module tb_jtag_mem_loader;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   logic [31:0] tb_dmem [512];
   logic [31:0] tb_imem [512];
   int          dmem_pulses;
   int          imem_pulses;

   jtag_mem_loader_if #(.WIDTH(32), .AW(9)) bus ();

   jtag_mem_loader #(.WIDTH(32), .DEPTH(512), .AW(9)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: commits on the edge after the strobe, like the real RAMs.
   always @(posedge clk) begin
      if (bus.dmem_we) begin
         tb_dmem[bus.mem_addr] <= bus.mem_wdata;
         dmem_pulses++;
      end
      if (bus.imem_we) begin
         tb_imem[bus.mem_addr] <= bus.mem_wdata;
         imem_pulses++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.Jen = 1'b0;
      bus.Jin = 32'h0;
      repeat (4) tick();
      checks++;
      if ({bus.dmem_we, bus.imem_we} !== 2'b00) begin
         errors++; $display("FAIL reset_strobes got %b want 00", {bus.dmem_we, bus.imem_we});
      end
      checks++;
      if (bus.Jout !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.mem_addr !== 9'h0) begin
         errors++; $display("FAIL reset_data Jout=%h wdata=%h addr=%h want 0", bus.Jout, bus.mem_wdata, bus.mem_addr);
      end
      checks++;
      if ({bus.cpu_hold, bus.load_done, bus.load_ovf} !== 3'b000) begin
         errors++; $display("FAIL reset_status got %b want 000", {bus.cpu_hold, bus.load_done, bus.load_ovf});
      end
      rst = 1'b0;
   endtask

   // Full load with Jin = 0x1000_0000+k, pausing 5 cycles after word 300.
   task automatic test_full_load();
      int d0, i0;
      logic       exp_d;
      logic [8:0] exp_a;
      logic [31:0] w;
      d0 = dmem_pulses;
      i0 = imem_pulses;
      for (int k = 0; k < 1024; k++) begin
         w = 32'h1000_0000 + k;
         bus.Jen = 1'b1;
         bus.Jin = w;
         tick();
         exp_d = (k < 512);
         exp_a = 9'(511 - (k % 512));
         checks++;
         if ({bus.dmem_we, bus.imem_we} !== {exp_d, ~exp_d} || bus.mem_addr !== exp_a || bus.mem_wdata !== w) begin
            errors++;
            $display("FAIL load_word k=%0d we=%b addr=%0d data=%h want we=%b addr=%0d data=%h",
                     k, {bus.dmem_we, bus.imem_we}, bus.mem_addr, bus.mem_wdata, {exp_d, ~exp_d}, exp_a, w);
         end
         checks++;
         if (bus.cpu_hold !== (k != 1023) || bus.load_done !== (k == 1023) || bus.Jout !== w) begin
            errors++;
            $display("FAIL load_status k=%0d hold=%b done=%b Jout=%h want hold=%b done=%b Jout=%h",
                     k, bus.cpu_hold, bus.load_done, bus.Jout, (k != 1023), (k == 1023), w);
         end
         if (k == 300) begin
            bus.Jen = 1'b0;
            bus.Jin = 32'hFFFF_FFFF;
            for (int p = 0; p < 5; p++) begin
               tick();
               checks++;
               if ({bus.dmem_we, bus.imem_we} !== 2'b00 || bus.cpu_hold !== 1'b1 ||
                   bus.mem_addr !== 9'd211 || bus.Jout !== 32'h1000_012C) begin
                  errors++;
                  $display("FAIL pause p=%0d we=%b hold=%b addr=%0d Jout=%h want 00 1 211 1000012c",
                           p, {bus.dmem_we, bus.imem_we}, bus.cpu_hold, bus.mem_addr, bus.Jout);
               end
            end
         end
      end
      bus.Jen = 1'b0;
      tick();
      checks++;
      if (dmem_pulses - d0 !== 512 || imem_pulses - i0 !== 512) begin
         errors++; $display("FAIL pulse_count dmem=%0d imem=%0d want 512 512", dmem_pulses - d0, imem_pulses - i0);
      end
      checks++;
      if (tb_dmem[511] !== 32'h1000_0000 || tb_dmem[0] !== 32'h1000_01FF) begin
         errors++; $display("FAIL dmem_ends d511=%h d0=%h want 10000000 100001ff", tb_dmem[511], tb_dmem[0]);
      end
      checks++;
      if (tb_imem[511] !== 32'h1000_0200 || tb_imem[0] !== 32'h1000_03FF) begin
         errors++; $display("FAIL imem_ends i511=%h i0=%h want 10000200 100003ff", tb_imem[511], tb_imem[0]);
      end
      checks++;
      if (tb_dmem[210] !== 32'h1000_012D) begin
         errors++; $display("FAIL resume_word dmem[210]=%h want 1000012d", tb_dmem[210]);
      end
      checks++;
      if ({bus.dmem_we, bus.imem_we} !== 2'b00 || bus.load_done !== 1'b1 || bus.cpu_hold !== 1'b0) begin
         errors++; $display("FAIL done_idle we=%b done=%b hold=%b want 00 1 0",
                            {bus.dmem_we, bus.imem_we}, bus.load_done, bus.cpu_hold);
      end
   endtask

   task automatic test_overflow();
      int d0, i0;
      d0 = dmem_pulses;
      i0 = imem_pulses;
      checks++;
      if (bus.load_ovf !== 1'b0) begin
         errors++; $display("FAIL ovf_before got %b want 0", bus.load_ovf);
      end
      bus.Jen = 1'b1;
      bus.Jin = 32'hDEAD_BEEF;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if ({bus.dmem_we, bus.imem_we} !== 2'b00 || bus.load_ovf !== 1'b1 ||
             bus.Jout !== 32'h1000_03FF || bus.load_done !== 1'b1) begin
            errors++;
            $display("FAIL overflow c=%0d we=%b ovf=%b Jout=%h done=%b want 00 1 100003ff 1",
                     c, {bus.dmem_we, bus.imem_we}, bus.load_ovf, bus.Jout, bus.load_done);
         end
      end
      bus.Jen = 1'b0;
      tick();
      checks++;
      if (bus.load_ovf !== 1'b1) begin
         errors++; $display("FAIL ovf_sticky got %b want 1", bus.load_ovf);
      end
      checks++;
      if (dmem_pulses != d0 || imem_pulses != i0 || tb_imem[0] !== 32'h1000_03FF) begin
         errors++; $display("FAIL ovf_no_write pulses=%0d/%0d imem0=%h want %0d/%0d 100003ff",
                            dmem_pulses, imem_pulses, tb_imem[0], d0, i0);
      end
   endtask

   task automatic test_post_load_rst();
      rst = 1'b1;
      tick();
      checks++;
      if ({bus.cpu_hold, bus.load_done, bus.load_ovf, bus.dmem_we, bus.imem_we} !== 5'b0 ||
          bus.Jout !== 32'h0 || bus.mem_addr !== 9'h0 || bus.mem_wdata !== 32'h0) begin
         errors++;
         $display("FAIL post_rst hold=%b done=%b ovf=%b we=%b Jout=%h addr=%h wdata=%h want all 0",
                  bus.cpu_hold, bus.load_done, bus.load_ovf, {bus.dmem_we, bus.imem_we},
                  bus.Jout, bus.mem_addr, bus.mem_wdata);
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({bus.cpu_hold, bus.load_done, bus.dmem_we, bus.imem_we} !== 4'b0 || tb_dmem[511] !== 32'h1000_0000) begin
         errors++; $display("FAIL post_rst_idle hold=%b done=%b we=%b dmem511=%h want 0 0 00 10000000",
                            bus.cpu_hold, bus.load_done, {bus.dmem_we, bus.imem_we}, tb_dmem[511]);
      end
   endtask

   task automatic test_mid_load_reset();
      logic [31:0] w;
      for (int k = 0; k < 700; k++) begin
         bus.Jen = 1'b1;
         bus.Jin = 32'h2000_0000 + k;
         tick();
      end
      checks++;
      if (bus.imem_we !== 1'b1 || bus.mem_addr !== 9'd324 || bus.mem_wdata !== 32'h2000_02BB) begin
         errors++; $display("FAIL word699 imem_we=%b addr=%0d data=%h want 1 324 200002bb",
                            bus.imem_we, bus.mem_addr, bus.mem_wdata);
      end
      rst = 1'b1;
      bus.Jin = 32'h2222_2222;
      tick();
      checks++;
      if ({bus.cpu_hold, bus.load_done, bus.dmem_we, bus.imem_we} !== 4'b0 ||
          bus.Jout !== 32'h0 || bus.mem_addr !== 9'h0 || bus.mem_wdata !== 32'h0) begin
         errors++; $display("FAIL mid_rst hold=%b done=%b we=%b Jout=%h addr=%h wdata=%h want all 0",
                            bus.cpu_hold, bus.load_done, {bus.dmem_we, bus.imem_we},
                            bus.Jout, bus.mem_addr, bus.mem_wdata);
      end
      rst = 1'b0;
      for (int k = 0; k < 1024; k++) begin
         w = 32'h3000_0000 + k;
         bus.Jin = w;
         tick();
         if (k == 0) begin
            checks++;
            if (bus.dmem_we !== 1'b1 || bus.mem_addr !== 9'd511 || bus.mem_wdata !== w) begin
               errors++; $display("FAIL restart_first we=%b addr=%0d data=%h want 1 511 %h",
                                  bus.dmem_we, bus.mem_addr, bus.mem_wdata, w);
            end
         end
         checks++;
         if (bus.load_done !== (k == 1023)) begin
            errors++; $display("FAIL restart_done k=%0d got %b want %b", k, bus.load_done, (k == 1023));
         end
      end
      bus.Jen = 1'b0;
      tick();
      checks++;
      if (tb_dmem[511] !== 32'h3000_0000 || tb_dmem[0] !== 32'h3000_01FF || tb_imem[0] !== 32'h3000_03FF) begin
         errors++; $display("FAIL restart_mem d511=%h d0=%h i0=%h want 30000000 300001ff 300003ff",
                            tb_dmem[511], tb_dmem[0], tb_imem[0]);
      end
   endtask

   task automatic test_collision();
      rst = 1'b1;
      bus.Jen = 1'b1;
      bus.Jin = 32'h5555_5555;
      tick();
      checks++;
      if (bus.Jout !== 32'h0 || {bus.dmem_we, bus.imem_we} !== 2'b00 || bus.load_ovf !== 1'b0) begin
         errors++; $display("FAIL collide_edge Jout=%h we=%b ovf=%b want 0 00 0",
                            bus.Jout, {bus.dmem_we, bus.imem_we}, bus.load_ovf);
      end
      rst = 1'b0;
      bus.Jen = 1'b0;
      tick();
      checks++;
      if ({bus.dmem_we, bus.imem_we} !== 2'b00 || bus.cpu_hold !== 1'b0 || bus.Jout !== 32'h0) begin
         errors++; $display("FAIL collide_next we=%b hold=%b Jout=%h want 00 0 0",
                            {bus.dmem_we, bus.imem_we}, bus.cpu_hold, bus.Jout);
      end
      bus.Jen = 1'b1;
      bus.Jin = 32'h6666_6666;
      tick();
      checks++;
      if (bus.dmem_we !== 1'b1 || bus.mem_addr !== 9'd511 || bus.cpu_hold !== 1'b1) begin
         errors++; $display("FAIL collide_cnt0 we=%b addr=%0d hold=%b want 1 511 1",
                            bus.dmem_we, bus.mem_addr, bus.cpu_hold);
      end
      bus.Jen = 1'b0;
      tick();
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      dmem_pulses = 0;
      imem_pulses = 0;
      rst         = 1'b1;
      bus.Jen     = 1'b0;
      bus.Jin     = 32'h0;
      test_reset();
      test_full_load();
      test_overflow();
      test_post_load_rst();
      test_mid_load_reset();
      test_collision();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
